stack_controller: RTL
=====================

STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 SHALL have parameter FIELD_COLS, default 16: playfield width in cells (2..511).
REQ-002 SHALL have parameter ROWS, default 12: rows to win (2..16).
REQ-003 SHALL have parameter INIT_SIZE, default 4: initial block width in cells (1..15, <= FIELD_COLS).
REQ-004 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse: begin a new game.
REQ-007 SHALL have port tick  in  1  one-cycle movement strobe.
REQ-008 SHALL have port stop  in  1  one-cycle pulse: player drops current block.
REQ-009 SHALL have port draw_ack  in  1  renderer finished current draw request.
REQ-010 SHALL have port curr_block_start / curr_block_end  out  9 each  moving block span, cells, inclusive.
REQ-011 SHALL have port prev_block_start / prev_block_end  out  9 each  top placed block span.
REQ-012 SHALL have port curr_block_size  out  4  current width in cells.
REQ-013 SHALL have port row  out  4  current row index, 0 = bottom.
REQ-014 SHALL have port draw_req  out  1  request renderer to draw curr span at row.
REQ-015 SHALL have ports game_over, win  out  1 each  terminal status flags.

Function
REQ-016 SHALL implement states IDLE, MOVE, TRIM, DRAW, CHECK, OVER, WIN.
REQ-017 SHALL, in IDLE/OVER/WIN on start: row=0, prev=0..FIELD_COLS-1, size=INIT_SIZE, curr=0..INIT_SIZE-1, dir=right, clear flags, go MOVE next cycle.
REQ-018 SHALL keep curr_block_end == curr_block_start + curr_block_size - 1 at all times outside reset.
REQ-019 SHALL, in MOVE on tick: shift curr by 1 cell in dir; at right edge (end==FIELD_COLS-1) dir flips and shift is left; at left edge (start==0) dir flips and shift is right; no shift if size==FIELD_COLS.
REQ-020 SHALL give stop priority over a same-cycle tick: no shift, go TRIM.
REQ-021 SHALL, in TRIM (1 cycle): if curr_end < prev_start or curr_start > prev_end, go OVER unchanged; else curr = max(starts)..min(ends), size = end-start+1, go DRAW.
REQ-022 SHALL, in DRAW, hold draw_req=1 with curr span and row stable until the cycle draw_ack=1, then go CHECK; draw_ack outside DRAW ignored.
REQ-023 SHALL, in CHECK (1 cycle): prev <= curr; if row==ROWS-1 go WIN; else row+1, curr_start=0, dir=right, go MOVE.
REQ-024 SHALL assert game_over only in OVER and win only in WIN, registered, held until start or reset.
REQ-025 SHALL ignore start outside IDLE/OVER/WIN, stop outside MOVE, tick outside MOVE.

Reset
REQ-026 SHALL, on resetn=0 at clk edge, enter IDLE: curr=0..0, prev=0..0, size=0, row=0, dir=right, draw_req=0, game_over=0, win=0.
REQ-027 SHALL abort any state (including DRAW mid-handshake) on reset; draw_req low the cycle after.

Configuration
REQ-028 SHALL, with LEVEL_SPEEDUP_EN defined, shift only on every N-th tick in MOVE, N = ROWS - row, via a tick counter cleared on entering MOVE.
REQ-029 SHALL, without LEVEL_SPEEDUP_EN, shift on every tick; no counter synthesised.

Verification
REQ-030 SHALL cover: reset, start, 3 ticks -> curr 3..6, size 4, row 0, dir right.
REQ-031 SHALL cover: row 0, stop at curr 13..16 (FIELD_COLS=20) -> DRAW with 13..16 size 4; draw_ack -> CHECK, prev 13..16, row 1, curr 0..3.
REQ-032 SHALL cover: prev 4..7, stop at curr 6..9 -> curr 6..7, size 2; at curr 9..12 -> game_over=1, draw_req never asserted.
REQ-033 SHALL cover: FIELD_COLS=16, curr 12..15 dir right, tick -> curr 11..14 dir left; at 0..3 dir left, tick -> 1..4.
REQ-034 SHALL cover: ROWS=2, two aligned drops with acks -> win=1 after second CHECK; start -> row 0, win=0.
REQ-035 SHALL cover: reset asserted while draw_req=1 -> IDLE, draw_req=0; with LEVEL_SPEEDUP_EN, ROWS=12, row 0 -> one shift per 12 ticks.

Source files
------------

// File: rtl/stack_controller.sv
// ---------------------------------------------------------------------------
// stack_controller
//
// Game controller for a "stacker" arcade game. A block of cells slides back
// and forth along a row of the playfield. When the player presses stop, the
// block is trimmed to the part that overlaps the block placed below it. The
// trimmed block is drawn by an external renderer, and then play continues on
// the next row up. A drop that misses the block below ends the game. Placing
// a block on the top row wins the game.
//
// Parameters
//   FIELD_COLS : playfield width in cells (2..511)
//   ROWS       : number of rows needed to win (2..16)
//   INIT_SIZE  : initial block width in cells (1..15, <= FIELD_COLS)
//
// Ports
//   clk               : system clock; all state changes on the rising edge
//   resetn            : synchronous, active-low reset
//   start             : one-cycle pulse that begins a new game
//   tick              : one-cycle movement strobe
//   stop              : one-cycle pulse that drops the current block
//   draw_ack          : renderer has finished the current draw request
//   curr_block_start  : first cell of the moving block (inclusive)
//   curr_block_end    : last cell of the moving block (inclusive)
//   prev_block_start  : first cell of the top placed block
//   prev_block_end    : last cell of the top placed block
//   curr_block_size   : width of the moving block in cells
//   row               : current row index, 0 = bottom
//   draw_req          : asks the renderer to draw the current span at row
//   game_over         : the game was lost (held until start or reset)
//   win               : the game was won (held until start or reset)
//
// Optional feature (compile-time macro LEVEL_SPEEDUP_EN)
//   When the macro is defined, the block moves only on every N-th tick,
//   where N = ROWS - row, so the block speeds up as the stack grows.
//   When the macro is not defined, the block moves on every tick and no
//   tick counter is built.
// ---------------------------------------------------------------------------
module stack_controller #(
  parameter int FIELD_COLS = 16,
  parameter int ROWS       = 12,
  parameter int INIT_SIZE  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       tick,
  input  logic       stop,
  input  logic       draw_ack,
  output logic [8:0] curr_block_start,
  output logic [8:0] curr_block_end,
  output logic [8:0] prev_block_start,
  output logic [8:0] prev_block_end,
  output logic [3:0] curr_block_size,
  output logic [3:0] row,
  output logic       draw_req,
  output logic       game_over,
  output logic       win
);

  localparam logic [8:0] FIELD_W  = 9'(FIELD_COLS);
  localparam logic [8:0] LAST_COL = 9'(FIELD_COLS - 1);
  localparam logic [3:0] INIT_W   = 4'(INIT_SIZE);
  localparam logic [8:0] INIT_END = 9'(INIT_SIZE - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    TRIM,
    DRAW,
    CHECK,
    OVER,
    WIN
  } state_t;

  state_t state;
  state_t state_next;

  logic       dir_right;

  logic       no_overlap;
  logic [8:0] trim_start;
  logic [8:0] trim_end;
  logic [3:0] trim_size;

  logic       full_width;
  logic       shift_dir_right;
  logic [8:0] shift_start;
  logic [8:0] shift_end;

  logic       tick_due;
  logic       do_shift;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic and status outputs. The status outputs are decoded
  // from the state register only, so each one changes once per clock edge.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    draw_req   = 1'b0;
    game_over  = 1'b0;
    win        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = MOVE;
      end
      OVER: begin
        game_over = 1'b1;
        if (start) state_next = MOVE;
      end
      WIN: begin
        win = 1'b1;
        if (start) state_next = MOVE;
      end
      MOVE: begin
        if (stop) state_next = TRIM;
      end
      TRIM: begin
        state_next = no_overlap ? OVER : DRAW;
      end
      DRAW: begin
        draw_req = 1'b1;
        if (draw_ack) state_next = CHECK;
      end
      CHECK: begin
        state_next = (row == LAST_ROW) ? WIN : MOVE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Overlap between the moving block and the block below it. The trimmed
  // span is the intersection of the two spans.
  // ---------------------------------------------------------------------
  always_comb begin
    no_overlap = (curr_block_end < prev_block_start) ||
                 (curr_block_start > prev_block_end);
    trim_start = (curr_block_start > prev_block_start) ? curr_block_start
                                                       : prev_block_start;
    trim_end   = (curr_block_end < prev_block_end) ? curr_block_end
                                                   : prev_block_end;
    trim_size  = 4'(trim_end - trim_start + 9'd1);
  end

  // ---------------------------------------------------------------------
  // One-cell shift with bounce. When the block is at the edge it is moving
  // towards, it reverses direction and moves one cell the other way on the
  // same tick. A block that fills the whole field never moves.
  // ---------------------------------------------------------------------
  always_comb begin
    full_width      = ({5'd0, curr_block_size} == FIELD_W);
    shift_dir_right = dir_right;
    shift_start     = curr_block_start;
    if (dir_right) begin
      if (curr_block_end == LAST_COL) begin
        shift_dir_right = 1'b0;
        shift_start     = curr_block_start - 9'd1;
      end else begin
        shift_start     = curr_block_start + 9'd1;
      end
    end else begin
      if (curr_block_start == 9'd0) begin
        shift_dir_right = 1'b1;
        shift_start     = curr_block_start + 9'd1;
      end else begin
        shift_start     = curr_block_start - 9'd1;
      end
    end
    shift_end = shift_start + {5'd0, curr_block_size} - 9'd1;
  end

`ifdef LEVEL_SPEEDUP_EN
  // Tick divider. The period shrinks as the row index grows. The count
  // restarts every time MOVE is entered, so each row starts on a full period.
  logic [4:0] tick_cnt;
  logic [4:0] tick_period;

  assign tick_period = 5'(ROWS) - {1'b0, row};
  assign tick_due    = (tick_cnt == tick_period - 5'd1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_cnt <= 5'd0;
    end else if ((state != MOVE) && (state_next == MOVE)) begin
      tick_cnt <= 5'd0;
    end else if ((state == MOVE) && tick && !stop) begin
      tick_cnt <= tick_due ? 5'd0 : tick_cnt + 5'd1;
    end
  end
`else
  assign tick_due = 1'b1;
`endif

  // A stop in the same cycle as a tick takes priority, so the block does
  // not move.
  assign do_shift = (state == MOVE) && tick && !stop && tick_due && !full_width;

  // ---------------------------------------------------------------------
  // Block, stack and row registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      curr_block_start <= 9'd0;
      curr_block_end   <= 9'd0;
      curr_block_size  <= 4'd0;
      prev_block_start <= 9'd0;
      prev_block_end   <= 9'd0;
      row              <= 4'd0;
      dir_right        <= 1'b1;
    end else begin
      case (state)
        IDLE, OVER, WIN: begin
          if (start) begin
            row              <= 4'd0;
            prev_block_start <= 9'd0;
            prev_block_end   <= LAST_COL;
            curr_block_size  <= INIT_W;
            curr_block_start <= 9'd0;
            curr_block_end   <= INIT_END;
            dir_right        <= 1'b1;
          end
        end
        MOVE: begin
          if (do_shift) begin
            curr_block_start <= shift_start;
            curr_block_end   <= shift_end;
            dir_right        <= shift_dir_right;
          end
        end
        TRIM: begin
          if (!no_overlap) begin
            curr_block_start <= trim_start;
            curr_block_end   <= trim_end;
            curr_block_size  <= trim_size;
          end
        end
        CHECK: begin
          prev_block_start <= curr_block_start;
          prev_block_end   <= curr_block_end;
          if (row != LAST_ROW) begin
            row              <= row + 4'd1;
            curr_block_start <= 9'd0;
            curr_block_end   <= {5'd0, curr_block_size} - 9'd1;
            dir_right        <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
